// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the L1 data-cache controller.
// Holds the address split (offset / index / tag), the tag-word layout
// {valid, dirty, tag}, the line geometry and the FSM state encodings.
package dcache_controller_pkg;

    localparam int ADDR_W    = 32;
    localparam int OFFSET_W  = 5;
    localparam int INDEX_W   = 5;
    localparam int TAG_W     = ADDR_W - OFFSET_W - INDEX_W;
    localparam int TAGWORD_W = TAG_W + 2;
    localparam int LINE_W    = 256;
    localparam int WORD_W    = 32;
    localparam int WSEL_W    = 3;

    // Tag word layout: valid is the MSB, dirty sits just below it.
    localparam int VALID_BIT = TAGWORD_W - 1;
    localparam int DIRTY_BIT = TAGWORD_W - 2;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_WRITEBACK = 3'd2;
    localparam logic [2:0] ST_ALLOCATE  = 3'd3;
    localparam logic [2:0] ST_REFILL    = 3'd4;

    function automatic logic [TAGWORD_W-1:0] make_tag_word(
        input logic             valid,
        input logic             dirty,
        input logic [TAG_W-1:0] tag
    );
        return {valid, dirty, tag};
    endfunction

    // Line-aligned memory address: offset bits are always zero.
    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0]   tag,
        input logic [INDEX_W-1:0] index
    );
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Combinational word access on a 256-bit cache line.
// Ports:
//   i_line        line read from the array
//   i_word_sel    word index within the line (address bits [4:2])
//   i_wdata       store data
//   o_rd_word     selected word, for loads
//   o_line_merged line with the selected word replaced by i_wdata, for stores
module dcache_line_merge
    import dcache_controller_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [WSEL_W-1:0] i_word_sel,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rd_word,
    output logic [LINE_W-1:0] o_line_merged
);

    always_comb begin
        o_rd_word     = i_line[i_word_sel*WORD_W +: WORD_W];
        o_line_merged = i_line;
        o_line_merged[i_word_sel*WORD_W +: WORD_W] = i_wdata;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   cpu_*                 MEM-stage request (req/we/addr/data in, data/stall out)
//   sram_*                L1 data/tag array: enable, write, index, line, tag word;
//                         sram_data_i / sram_tag_i are combinational reads
//   mem_*                 line-level memory port with one-cycle mem_ack_i
//   dbg_state_o           current FSM state
//
// Handshakes: the CPU keeps req/we/addr/data stable for as long as
// cpu_stall_o is high; a request completes in the first cycle it is seen
// with cpu_stall_o low. On the memory side, enable/write/addr/data are held
// stable until the cycle in which mem_ack_i is high; the request is
// withdrawn the following cycle. An ack seen in any other state is ignored.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 sram_enable_o,
    output logic                 sram_write_o,
    output logic [INDEX_W-1:0]   sram_addr_o,
    output logic [LINE_W-1:0]    sram_data_o,
    output logic [TAGWORD_W-1:0] sram_tag_o,
    input  logic [LINE_W-1:0]    sram_data_i,
    input  logic [TAGWORD_W-1:0] sram_tag_i,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_W-1:0]    mem_data_o,
    input  logic [LINE_W-1:0]    mem_data_i,
    input  logic                 mem_ack_i,
    output logic [2:0]           dbg_state_o
);

    logic [2:0]         r_state;
    logic [INDEX_W-1:0] r_init_cnt;
    logic [LINE_W-1:0]  r_line_buf;
    logic [TAG_W-1:0]   r_victim_tag;
    logic [2:0]         w_state_nxt;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [WSEL_W-1:0]  w_word_sel;
    logic [TAG_W-1:0]   w_stored_tag;
    logic               w_valid;
    logic               w_dirty;
    logic               w_hit;
    logic [WORD_W-1:0]  w_rd_word;
    logic [LINE_W-1:0]  w_line_merged;
    logic               w_unused;

    assign w_index      = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign w_tag        = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_word_sel   = cpu_addr_i[2 +: WSEL_W];
    assign w_stored_tag = sram_tag_i[TAG_W-1:0];
    assign w_valid      = sram_tag_i[VALID_BIT];
    assign w_dirty      = sram_tag_i[DIRTY_BIT];
    assign w_hit        = cpu_req_i & w_valid & (w_stored_tag == w_tag);
    // Addresses are word-aligned, so the byte-offset bits carry no information.
    assign w_unused     = ^cpu_addr_i[1:0];
    assign dbg_state_o  = r_state;

    dcache_line_merge u_line_merge (
        .i_line        (sram_data_i),
        .i_word_sel    (w_word_sel),
        .i_wdata       (cpu_data_i),
        .o_rd_word     (w_rd_word),
        .o_line_merged (w_line_merged)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:
                if (r_init_cnt == {INDEX_W{1'b1}}) w_state_nxt = ST_IDLE;
            ST_IDLE:
                if (cpu_req_i && !w_hit)
                    w_state_nxt = (w_valid && w_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            ST_WRITEBACK:
                if (mem_ack_i) w_state_nxt = ST_ALLOCATE;
            ST_ALLOCATE:
                if (mem_ack_i) w_state_nxt = ST_REFILL;
            ST_REFILL:
                w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= ST_INIT;
            r_init_cnt   <= '0;
            r_line_buf   <= '0;
            r_victim_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_INIT:
                    r_init_cnt <= r_init_cnt + 1'b1;
                ST_IDLE:
                    // The victim line and tag are snapshotted at miss detect so
                    // the write-back stays stable regardless of array reads.
                    if (cpu_req_i && !w_hit) begin
                        r_line_buf   <= sram_data_i;
                        r_victim_tag <= w_stored_tag;
                    end
                ST_ALLOCATE:
                    if (mem_ack_i) r_line_buf <= mem_data_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = w_index;
        sram_data_o   = '0;
        sram_tag_o    = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        case (r_state)
            ST_INIT: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_addr_o   = r_init_cnt;
            end
            ST_IDLE: begin
                sram_enable_o = 1'b1;
                if (!cpu_req_i) begin
                    cpu_stall_o = 1'b0;
                end else if (w_hit) begin
                    cpu_stall_o = 1'b0;
                    if (cpu_we_i) begin
                        sram_write_o = 1'b1;
                        sram_data_o  = w_line_merged;
                        sram_tag_o   = make_tag_word(1'b1, 1'b1, w_tag);
                    end else begin
                        cpu_data_o = w_rd_word;
                    end
                end
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = line_addr(r_victim_tag, w_index);
                mem_data_o   = r_line_buf;
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = line_addr(w_tag, w_index);
            end
            ST_REFILL: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_data_o   = r_line_buf;
                sram_tag_o    = make_tag_word(1'b1, 1'b0, w_tag);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed testbench for dcache_controller: behavioural SRAM array model,
// hand-driven memory acks, hand-computed expected values.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i;
    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [ADDR_W-1:0]    cpu_addr_i;
    logic [WORD_W-1:0]    cpu_data_i;
    logic [WORD_W-1:0]    cpu_data_o;
    logic                 cpu_stall_o;
    logic                 sram_enable_o;
    logic                 sram_write_o;
    logic [INDEX_W-1:0]   sram_addr_o;
    logic [LINE_W-1:0]    sram_data_o;
    logic [TAGWORD_W-1:0] sram_tag_o;
    logic [LINE_W-1:0]    sram_data_i;
    logic [TAGWORD_W-1:0] sram_tag_i;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [LINE_W-1:0]    mem_data_o;
    logic [LINE_W-1:0]    mem_data_i;
    logic                 mem_ack_i;
    logic [2:0]           dbg_state_o;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_addr_o   (sram_addr_o),
        .sram_data_o   (sram_data_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_i   (sram_data_i),
        .sram_tag_i    (sram_tag_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- SRAM array model ----------------
    logic [LINE_W-1:0]    sram_data_arr [32];
    logic [TAGWORD_W-1:0] sram_tag_arr  [32];
    logic                 tb_preload;

    assign sram_data_i = sram_data_arr[sram_addr_o];
    assign sram_tag_i  = sram_tag_arr[sram_addr_o];

    // Preload garbage marked valid+dirty with tag 0 so that a missing
    // tag clear would turn the first cold load into a false hit.
    always @(posedge clk) begin
        if (tb_preload) begin
            for (int i = 0; i < 32; i++) begin
                sram_data_arr[i] <= {8{32'hCAFE0000 + i}};
                sram_tag_arr[i]  <= 24'hC00000;
            end
        end else if (sram_enable_o && sram_write_o) begin
            sram_data_arr[sram_addr_o] <= sram_data_o;
            sram_tag_arr[sram_addr_o]  <= sram_tag_o;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
        cpu_req_i  = req;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = data;
        #1;
    endtask

    // Present a one-cycle ack with the given refill data.
    task automatic mem_ack(input logic [255:0] line);
        mem_ack_i  = 1'b1;
        mem_data_i = line;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    logic [255:0] line1, line1_mod, line2, line3, line3_mod;

    initial begin
        line1 = make_line(32'hA0000000);
        line1[95:64] = 32'hDEADBEEF;
        line1_mod = line1;
        line1_mod[63:32] = 32'h12345678;
        line2 = make_line(32'hB0000000);
        line3 = make_line(32'hC0000000);
        line3_mod = line3;
        line3_mod[31:0] = 32'h55AA55AA;

        rst_i      = 1'b0;
        tb_preload = 1'b1;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);

        // ---- reset ----
        tick();
        tb_preload = 1'b0;
        check_val("rst_state", dbg_state_o, ST_INIT);
        check_val("rst_stall", cpu_stall_o, 1'b1);
        check_val("rst_mem_en", {mem_enable_o, mem_write_o}, 2'b00);
        check_val("rst_cpu_data", cpu_data_o, 32'h0);
        rst_i = 1'b1;
        #1;

        // ---- tag initialisation sweep ----
        for (int k = 0; k < 32; k++) begin
            check_val("init_sweep", {cpu_stall_o, sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o},
                      {1'b1, 1'b1, 1'b1, 5'(k), 24'h0});
            tick();
        end
        check_val("init_done_state", dbg_state_o, ST_IDLE);
        check_val("idle_noreq", {cpu_stall_o, sram_write_o, mem_enable_o}, 3'b000);
        check_val("init_tag2", sram_tag_arr[2], 24'h0);
        check_val("init_tag31", sram_tag_arr[31], 24'h0);

        // ---- cold load 0x40 ----
        cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
        check_val("cold_stall", {cpu_stall_o, sram_addr_o}, {1'b1, 5'd2});
        tick();
        check_val("cold_alloc", {mem_enable_o, mem_write_o, mem_addr_o}, {2'b10, 32'h40});
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("cold_wait", {mem_enable_o, cpu_stall_o}, 2'b11);
        end
        mem_ack(line1);
        check_val("cold_refill_ctl", {mem_enable_o, sram_write_o, sram_addr_o, sram_tag_o},
                  {1'b0, 1'b1, 5'd2, 24'h800000});
        check_val("cold_refill_data", sram_data_o, line1);
        tick();
        exp_q.push_back(32'hA0000000);
        check_val("cold_hit_stall", cpu_stall_o, 1'b0);
        check_val("cold_hit_data", cpu_data_o, exp_q.pop_front());
        cpu_drive(1'b1, 1'b0, 32'h48, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        check_val("ld48", {cpu_stall_o, cpu_data_o}, {1'b0, exp_q.pop_front()});

        // ---- store hit 0x44 ----
        cpu_drive(1'b1, 1'b1, 32'h44, 32'h12345678);
        check_val("st_hit_ctl", {cpu_stall_o, sram_write_o, sram_tag_o}, {1'b0, 1'b1, 24'hC00000});
        check_val("st_hit_data", sram_data_o, line1_mod);
        tick();
        cpu_drive(1'b1, 1'b0, 32'h44, 32'h0);
        exp_q.push_back(32'h12345678);
        check_val("ld44", {cpu_stall_o, cpu_data_o}, {1'b0, exp_q.pop_front()});

        // ---- dirty conflict load 0x440 ----
        cpu_drive(1'b1, 1'b0, 32'h440, 32'h0);
        check_val("dirty_stall", cpu_stall_o, 1'b1);
        tick();
        check_val("wb_ctl", {dbg_state_o, mem_enable_o, mem_write_o, mem_addr_o}, {ST_WRITEBACK, 2'b11, 32'h40});
        check_val("wb_data", mem_data_o, line1_mod);
        tick();
        tick();
        check_val("wb_hold", {mem_enable_o, mem_write_o, mem_addr_o}, {2'b11, 32'h40});
        mem_ack(256'h0);
        check_val("wb_to_alloc", {mem_enable_o, mem_write_o, mem_addr_o}, {2'b10, 32'h440});
        tick();
        mem_ack(line2);
        check_val("refill2_tag", {sram_write_o, sram_tag_o}, {1'b1, 24'h800001});
        tick();
        exp_q.push_back(32'hB0000000);
        check_val("ld440", {cpu_stall_o, cpu_data_o}, {1'b0, exp_q.pop_front()});

        // ---- store miss 0x840 (victim clean) ----
        cpu_drive(1'b1, 1'b1, 32'h840, 32'h55AA55AA);
        check_val("stmiss_detect", {cpu_stall_o, sram_write_o}, 2'b10);
        tick();
        check_val("stmiss_alloc", {mem_enable_o, mem_write_o, mem_addr_o}, {2'b10, 32'h840});
        mem_ack(line3);
        check_val("stmiss_refill", {sram_write_o, sram_tag_o, mem_write_o}, {1'b1, 24'h800002, 1'b0});
        check_val("stmiss_refill_data", sram_data_o, line3);
        tick();
        check_val("stmiss_hitwr", {cpu_stall_o, sram_write_o, sram_tag_o}, {1'b0, 1'b1, 24'hC00002});
        check_val("stmiss_hitwr_data", sram_data_o, line3_mod);
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_val("stmiss_tag_arr", sram_tag_arr[2], 24'hC00002);

        // ---- reset while waiting in ALLOCATE ----
        cpu_drive(1'b1, 1'b0, 32'h1060, 32'h0);
        check_val("rst_mid_detect", cpu_stall_o, 1'b1);
        tick();
        check_val("rst_mid_alloc", {mem_enable_o, mem_addr_o}, {1'b1, 32'h1060});
        rst_i = 1'b0;
        tick();
        check_val("rst_mid_drop", {dbg_state_o, mem_enable_o, cpu_stall_o}, {ST_INIT, 1'b0, 1'b1});
        rst_i = 1'b1;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack(256'hFFFF);
        check_val("late_ack", {dbg_state_o, sram_addr_o, mem_enable_o}, {ST_INIT, 5'd1, 1'b0});
        repeat (31) tick();
        check_val("reinit_idle", {dbg_state_o, cpu_stall_o}, {ST_IDLE, 1'b0});
        cpu_drive(1'b1, 1'b0, 32'h48, 32'h0);
        check_val("reinit_miss", cpu_stall_o, 1'b1);
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data-cache controller.
- Sits between the CPU MEM stage and the data memory.
- Acts as the initiator that drives the L1 data/tag SRAM array: index, line data, tag+valid+dirty, enable, write.
- Stalls the CPU on a miss, writes back dirty victims, refills lines from memory, and zero-initialises all tags after reset.

Parameters:
- ADDR_W, 32, byte address width
- OFFSET_W, 5, line offset bits (32-byte / 256-bit line)
- INDEX_W, 5, index bits (32 lines)
- TAG_W, 22, address tag bits (ADDR_W-OFFSET_W-INDEX_W); stored tag word is TAG_W+2 = 24 bits: {valid, dirty, tag}

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- cpu_req_i  in  1  CPU access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  word-aligned byte address
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data
- cpu_stall_o  out  1  CPU must hold request and pipeline
- sram_enable_o  out  1  array enable
- sram_write_o  out  1  array write strobe
- sram_addr_o  out  INDEX_W  line index
- sram_data_o  out  256  line write data
- sram_tag_o  out  TAG_W+2  tag write word
- sram_data_i  in  256  line read data (combinational)
- sram_tag_i  in  TAG_W+2  tag read word (combinational)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = line write-back
- mem_addr_o  out  ADDR_W  line address, low OFFSET_W bits 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i=0 at posedge):
  - state=INIT, init counter=0.
  - cpu_stall_o=1, mem_enable_o=0, mem_write_o=0, sram_write_o=0, cpu_data_o=0, line buffer=0.
  - A reset asserted mid-transaction abandons it; the memory side tolerates a dropped request.
- INIT:
  - Each cycle writes tag word 0 and data 0 to index = counter (sram_enable_o=1, sram_write_o=1).
  - Counter increments; after index 2^INDEX_W-1 → IDLE (32 cycles with defaults).
  - cpu_stall_o=1 throughout.
- IDLE:
  - sram_enable_o=1, sram_addr_o=cpu_addr_i[OFFSET_W+:INDEX_W].
  - hit = cpu_req_i & valid & (stored tag == cpu_addr_i[ADDR_W-1-:TAG_W]).
  - Read hit: cpu_data_o = word cpu_addr_i[4:2] of sram_data_i; stall 0; zero extra latency.
  - Write hit, same cycle:
    - sram_write_o=1.
    - Data = line with the selected word replaced by cpu_data_i.
    - Tag word = {1, 1, tag}.
    - Stall 0.
  - Miss: cpu_stall_o=1 combinationally in the detect cycle.
    - Next state WRITEBACK if valid & dirty, else ALLOCATE.
  - No request: outputs idle, stall 0.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {stored tag, index, 0}; mem_data_o = victim line (registered at miss detect).
  - Held stable until mem_ack_i → ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {cpu tag, index, 0}.
  - On mem_ack_i: capture mem_data_i into the line buffer → REFILL.
- REFILL:
  - One cycle: sram_write_o=1, data = line buffer, tag word = {1, 0, cpu tag} → IDLE.
  - IDLE then re-evaluates as a hit and completes the load or store (write-allocate).
- mem_enable_o drops the cycle after ack.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- The CPU holds cpu_req_i/cpu_we_i/cpu_addr_i/cpu_data_i stable while cpu_stall_o=1.
- Miss latency:
  - Clean miss = 1 (detect) + ack wait + 1 (REFILL) cycles before the hit cycle.
  - Dirty miss adds the write-back wait.

Decomposition:
- Shared defines header holds: INDEX/OFFSET/TAG widths, tag-word bit positions (valid = MSB, dirty = MSB-1), line width 256, and the state encodings INIT/IDLE/WRITEBACK/ALLOCATE/REFILL.
- One natural sub-module, dcache_line_merge (combinational):
  - Word select for loads.
  - Word replace for stores on the 256-bit line.

Test Plan:
- Reset 1 cycle low → 32 cycles of stall with sram_write_o=1 at indices 0..31, tag 0; then stall=0 with no request.
- Load 0x0000_0040 (cold) → stall high.
  - mem read at 0x40, ack after 5 cycles with line word2 = 0xDEADBEEF.
  - Refill tag {1, 0, 0}.
  - Load 0x48 returns 0xDEADBEEF with no further miss.
- Store 0x44 ← 0x12345678 on a resident line → no stall; SRAM written with word1 replaced, tag {1, 1, 0}; subsequent load 0x44 = 0x12345678.
- Load 0x0000_0440 (same index 2, tag 1) after the dirty store:
  - Write-back at 0x40 with the modified line first.
  - Then read at 0x440.
  - New tag {1, 0, 1}.
- Store miss to 0x0000_0840 → write-allocate refill, then hit-write sets dirty; no memory write of store data directly.
- Reset asserted during ALLOCATE while waiting for ack → mem_enable_o=0 next cycle, INIT restarts, late ack is ignored.
